// File: rtl/fifo_packer.sv
// Narrow-to-wide packer between an upstream FIFO dequeue side and a downstream FIFO enqueue side.
// Define FIFO_PACKER_FLUSH_EN to add FLUSH / OUT_LANES for emitting zero-padded partial words.
module fifo_packer #(
  parameter int width = 8,
  parameter int ratio = 4,
  parameter int cntw  = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CLR,
  input  logic [width-1:0]       IN_DATA,
  input  logic                   IN_EMPTY_N,
  output logic                   IN_DEQ,
  output logic [width*ratio-1:0] OUT_DATA,
  output logic                   OUT_ENQ,
  input  logic                   OUT_FULL_N,
  output logic [cntw-1:0]        PEND
`ifdef FIFO_PACKER_FLUSH_EN
  ,
  input  logic                   FLUSH,
  output logic [cntw:0]          OUT_LANES
`endif
);

  localparam logic [cntw-1:0] last_lane = cntw'(ratio - 1);

  logic [cntw-1:0]        cnt_reg, cnt_next;
  logic                   out_valid_reg, out_valid_next;
  logic [width*ratio-1:0] out_reg;
  logic [width*ratio-1:0] packed_word;
  logic                   at_last, slot_free, flush_go, load;

  always_comb begin
    at_last   = (cnt_reg == last_lane);
    OUT_ENQ   = out_valid_reg && OUT_FULL_N && !CLR;
    slot_free = !out_valid_reg || OUT_ENQ;
`ifdef FIFO_PACKER_FLUSH_EN
    // A pending flush needs the output slot, so it blocks further accepts until the slot frees.
    IN_DEQ    = IN_EMPTY_N && !CLR && (slot_free || (!at_last && !FLUSH));
    flush_go  = FLUSH && slot_free && !CLR && ((cnt_reg != '0) || IN_DEQ);
`else
    IN_DEQ    = IN_EMPTY_N && !CLR && (!at_last || slot_free);
    flush_go  = 1'b0;
`endif
    load      = (IN_DEQ && at_last) || flush_go;

    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    if (CLR) begin
      cnt_next       = '0;
      out_valid_next = 1'b0;
    end else if (load) begin
      cnt_next       = '0;
      out_valid_next = 1'b1;
    end else begin
      if (IN_DEQ)  cnt_next = cnt_reg + 1'b1;
      if (OUT_ENQ) out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Lanes below cnt come from storage, lane cnt is the word arriving now, higher lanes read zero.
  genvar gi;
  generate
    for (gi = 0; gi < ratio; gi++) begin : g_lane
      logic [width-1:0] stored;
      if (gi < ratio - 1) begin : g_reg
        logic [width-1:0] lane_reg;
        always_ff @(posedge CLK) begin
          if (IN_DEQ && (cnt_reg == cntw'(gi))) lane_reg <= IN_DATA;
        end
        assign stored = lane_reg;
      end else begin : g_top
        assign stored = '0;
      end
      assign packed_word[gi*width +: width] =
        (cntw'(gi) < cnt_reg) ? stored :
        ((cntw'(gi) == cnt_reg) && IN_DEQ) ? IN_DATA : '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (load) out_reg <= packed_word;
  end

`ifdef FIFO_PACKER_FLUSH_EN
  logic [cntw:0] lanes_reg;
  always_ff @(posedge CLK) begin
    if (load) lanes_reg <= {1'b0, cnt_reg} + {{cntw{1'b0}}, IN_DEQ};
  end
  assign OUT_LANES = lanes_reg;
`endif

  assign OUT_DATA = out_reg;
  assign PEND     = cnt_reg;

  a_deq_needs_data: assert property (@(posedge CLK) disable iff (!RST_N) IN_DEQ |-> IN_EMPTY_N);

endmodule
